// File: rtl/pwm_generator.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// pwm_generator
//
// Fixed-period PWM stage running on the divided 3.125 MHz clock. The duty
// cycle is double-buffered: duty_load captures a (saturated) request into a
// shadow register, and the shadow is copied into the active duty only at a
// period start, so a period is never cut short or stretched mid-flight.
//
// Ports:
//   clk_3125KHz   in   divided clock, all logic on posedge
//   rst           in   asynchronous active-high reset
//   en            in   run enable; low forces the generator idle
//   duty_cycle    in   requested high time in cycles (0..PERIOD), CNT_W+1 bits
//   duty_load     in   one-cycle strobe capturing duty_cycle into the shadow
//   pwm_signal    out  registered PWM waveform
//   period_start  out  registered one-cycle pulse during cycle k=0 of a period
//   duty_active   out  duty value applied to the current period
// ---------------------------------------------------------------------------
module pwm_generator #(
    parameter int PERIOD = 16,
    parameter int CNT_W  = 4
) (
    input  logic             clk_3125KHz,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W:0]   duty_cycle,
    input  logic             duty_load,
    output logic             pwm_signal,
    output logic             period_start,
    output logic [CNT_W:0]   duty_active
);

    localparam logic [CNT_W:0]   PERIOD_V = (CNT_W + 1)'(PERIOD);
    localparam logic [CNT_W-1:0] LAST_K   = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] cnt;        // phase k of the cycle currently on the outputs
    logic [CNT_W:0]   shadow;     // next period's duty
    logic             running;    // a period is in progress (last edge was enabled)

    logic [CNT_W:0]   duty_sat;
    logic [CNT_W:0]   duty_next;
    logic             start;
    logic [CNT_W-1:0] cnt_next;

    // NOTE: every signal written here gets a value on every path, so no
    // latch is inferred.
    always_comb begin
        duty_sat  = (duty_cycle > PERIOD_V) ? PERIOD_V : duty_cycle;
        // A load on the boundary edge bypasses the shadow so it applies now.
        duty_next = duty_load ? duty_sat : shadow;
        // First enabled edge after idle/reset, or wrap from PERIOD-1.
        start     = !running || (cnt == LAST_K);
        cnt_next  = cnt + 1'b1;
    end

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_3125KHz or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            shadow       <= '0;
            running      <= 1'b0;
            duty_active  <= '0;
            pwm_signal   <= 1'b0;
            period_start <= 1'b0;
        end else begin
            // The shadow follows duty_load even while idle.
            if (duty_load) begin
                shadow <= duty_sat;
            end

            if (!en) begin
                // Abandon any partial period; duty_active is kept.
                cnt          <= '0;
                running      <= 1'b0;
                pwm_signal   <= 1'b0;
                period_start <= 1'b0;
            end else if (start) begin
                cnt          <= '0;
                running      <= 1'b1;
                duty_active  <= duty_next;
                pwm_signal   <= (duty_next != '0);
                period_start <= 1'b1;
            end else begin
                cnt          <= cnt_next;
                // High time is contiguous from k=0; a duty of PERIOD never
                // drops low because cnt_next never reaches PERIOD.
                pwm_signal   <= ({1'b0, cnt_next} < duty_active);
                period_start <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pwm_generator.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_pwm_generator
//
// Directed bench for pwm_generator (PERIOD=16, CNT_W=4). Each directed step
// pushes the expected per-cycle outputs {period_start, pwm_signal,
// duty_active} into a scoreboard queue; every clock the oldest entry is
// popped and compared against the DUT, sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_pwm_generator;

    localparam int PERIOD = 16;
    localparam int CNT_W  = 4;

    logic             clk_3125KHz = 1'b0;
    logic             rst = 1'b0;
    logic             en = 1'b0;
    logic [CNT_W:0]   duty_cycle = '0;
    logic             duty_load = 1'b0;
    logic             pwm_signal;
    logic             period_start;
    logic [CNT_W:0]   duty_active;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic           ps;
        logic           pwm;
        logic [CNT_W:0] duty;
    } exp_t;

    exp_t sb[$];

    pwm_generator #(.PERIOD(PERIOD), .CNT_W(CNT_W)) dut (
        .clk_3125KHz  (clk_3125KHz),
        .rst          (rst),
        .en           (en),
        .duty_cycle   (duty_cycle),
        .duty_load    (duty_load),
        .pwm_signal   (pwm_signal),
        .period_start (period_start),
        .duty_active  (duty_active)
    );

    // 3.125 MHz -> 320 ns period
    always #160 clk_3125KHz = ~clk_3125KHz;

    initial begin
        #(320 * 3000);
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [CNT_W:0] obs, input logic [CNT_W:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic ps, input logic pwm, input logic [CNT_W:0] duty);
        exp_t e;
        e.ps   = ps;
        e.pwm  = pwm;
        e.duty = duty;
        sb.push_back(e);
    endtask

    // Expected outputs for the first n cycles of a period with duty d.
    task automatic push_period(input int d, input int n);
        logic [CNT_W:0] dv;
        dv = d[CNT_W:0];
        for (int k = 0; k < n; k++) begin
            push_exp(k == 0, k < d, dv);
        end
    endtask

    // One clock: drive inputs, take the posedge, compare on the negedge.
    task automatic step(input logic load, input logic [CNT_W:0] val);
        exp_t e;
        duty_load  = load;
        duty_cycle = val;
        @(posedge clk_3125KHz);
        @(negedge clk_3125KHz);
        duty_load = 1'b0;
        cyc++;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_empty@%0d: got no entry expected one", cyc);
        end else begin
            e = sb.pop_front();
            check($sformatf("period_start@%0d", cyc), {4'b0, period_start}, {4'b0, e.ps});
            check($sformatf("pwm_signal@%0d", cyc),   {4'b0, pwm_signal},   {4'b0, e.pwm});
            check($sformatf("duty_active@%0d", cyc),  duty_active,          e.duty);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, duty_cycle);
        end
    endtask

    initial begin
        // Asynchronous reset, checked before any clock edge.
        #5 rst = 1'b1;
        #5;
        check("reset_pwm",   {4'b0, pwm_signal},   5'd0);
        check("reset_start", {4'b0, period_start}, 5'd0);
        check("reset_duty",  duty_active,          5'd0);
        push_exp(1'b0, 1'b0, 5'd0);
        push_exp(1'b0, 1'b0, 5'd0);
        run(2);
        rst = 1'b0;

        // Duty 5, loaded together with en: two full periods.
        en = 1'b1;
        push_period(5, 16);
        step(1'b1, 5'd5);
        run(15);
        push_period(5, 16);
        run(16);

        // Load 12 at k=7: current period keeps 5, next uses 12.
        push_period(5, 16);
        run(7);
        step(1'b1, 5'd12);
        run(8);
        push_period(12, 16);
        run(16);

        // Load 3 on the wrap edge bypasses the shadow; load 9 at k=14 waits.
        push_period(3, 16);
        step(1'b1, 5'd3);
        run(13);
        step(1'b1, 5'd9);
        run(1);
        push_period(9, 16);
        run(16);

        // Duty 0: always low.
        push_period(0, 16);
        step(1'b1, 5'd0);
        run(15);
        push_period(0, 16);
        run(16);

        // Duty 16: continuously high across three wraps.
        push_period(16, 16);
        step(1'b1, 5'd16);
        run(15);
        for (int p = 0; p < 3; p++) begin
            push_period(16, 16);
            run(16);
        end

        // Duty 31 saturates to 16.
        push_period(16, 16);
        step(1'b1, 5'd31);
        run(15);

        // Duty 8, en dropped at k=3, then re-enabled for a fresh period.
        push_period(8, 4);
        step(1'b1, 5'd8);
        run(3);
        en = 1'b0;
        push_exp(1'b0, 1'b0, 5'd8);
        push_exp(1'b0, 1'b0, 5'd8);
        run(2);
        en = 1'b1;
        push_period(8, 16);
        run(16);

        // Duty 10, asynchronous reset between edges at k=2.
        push_period(10, 3);
        step(1'b1, 5'd10);
        run(2);
        rst = 1'b1;
        #1;
        check("midreset_pwm",   {4'b0, pwm_signal},   5'd0);
        check("midreset_start", {4'b0, period_start}, 5'd0);
        check("midreset_duty",  duty_active,          5'd0);
        push_exp(1'b0, 1'b0, 5'd0);
        run(1);
        rst = 1'b0;
        // Shadow was lost: fresh period with duty 0.
        push_period(0, 16);
        run(16);

        total++;
        assert (sb.size() == 0) else begin
            bad++;
            $error("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pwm_generator.md
Name: pwm_generator

Overview:
- PWM stage directly downstream of the 50 MHz → 3.125 MHz frequency divider; clocked by its clk_3125KHz output.
- Produces a fixed-period PWM waveform with a programmable duty cycle.
- Duty updates are double-buffered (shadow → active) at period boundaries so the waveform never glitches.
- Default PERIOD=16 gives a 195.3125 kHz PWM with 1/16 duty resolution.

Parameters:
- PERIOD, 16, clock cycles per PWM period (2 ≤ PERIOD ≤ 2^CNT_W)
- CNT_W, 4, phase counter width

Ports:
- clk_3125KHz  input  1  divided clock; all logic on posedge
- rst  input  1  asynchronous, active-high reset
- en  input  1  run enable; low holds the generator idle
- duty_cycle  input  CNT_W+1  requested high time in cycles, 0..PERIOD
- duty_load  input  1  one-cycle strobe; captures duty_cycle into the shadow register
- pwm_signal  output  1  registered PWM output
- period_start  output  1  registered one-cycle pulse marking cycle k=0 of each period
- duty_active  output  CNT_W+1  duty value applied to the current period

Behaviour:
- Reset (rst=1, asynchronous): outputs change immediately, no clock needed.
  - pwm_signal=0, period_start=0, duty_active=0.
  - Internal phase counter = 0; shadow = 0.
  - All logic holds while rst=1; it restarts at the first posedge after deassertion.
- Shadow capture:
  - Captured on any posedge with duty_load=1, regardless of en.
  - duty_cycle > PERIOD is saturated to PERIOD at capture.
- Idle (en=0):
  - Phase counter forced to 0; pwm_signal=0; period_start=0.
  - duty_active holds its last value.
- Running (en=1): the phase counter k counts 0..PERIOD-1 and wraps to 0.
  - Output registers present the state of cycle k in the clock cycle after the edge that enters k.
- Period start: occurs on the first enabled edge after idle or reset, and on every wrap from PERIOD-1 to 0. At that edge:
  - duty_active ← shadow. If duty_load=1 on the same edge, the new saturated duty_cycle bypasses the shadow into duty_active.
  - period_start=1 for exactly one cycle.
  - pwm_signal=1 for this cycle if the new duty_active > 0.
- Within a period: pwm_signal = (k < duty_active).
  - Each period has exactly duty_active high cycles followed by PERIOD-duty_active low cycles.
  - The high time is contiguous from k=0.
- Boundary cases:
  - duty_active=0: pwm_signal stays low for the whole period.
  - duty_active=PERIOD: pwm_signal stays continuously high across wraps, with no low cycle at the boundary.
  - Mid-period duty_load: affects the shadow only; the current period completes with the old duty_active.
  - Multiple loads within one period: the last one wins.
  - en dropped mid-period: output goes low and the counter goes to 0 on the next edge. The partial period is abandoned; re-enabling starts a fresh period.
  - rst asserted mid-period: all outputs clear immediately; the shadow is lost (value 0).
- Latency:
  - duty_load → new duty visible on pwm_signal at the next period start. This is the same edge if the load coincides with the boundary, otherwise up to PERIOD cycles later.

Test Plan:
- Reset, then load duty 5 and set en=1:
  - period_start pulses every 16 cycles.
  - pwm_signal is high for 5 cycles, then low for 11, repeating.
  - duty_active=5.
- Load duty 12 at k=7 of a duty-5 period:
  - The current period still shows 5 high cycles.
  - The next period shows 12 high / 4 low; duty_active changes to 12 on the period_start edge.
- duty_load=1 with duty 3 on the exact wrap edge:
  - The new period uses 3 immediately (bypass).
  - The bench also checks that a load at k=14 waits for the next boundary.
- Duty 0, then duty 16, then duty 31:
  - Duty 0: pwm_signal always low.
  - Duty 16: pwm_signal always high across three consecutive wraps.
  - Duty 31: saturated to 16, so duty_active=16.
- en=0 at k=3 of a duty-8 period:
  - pwm_signal goes low next cycle and the counter goes to 0.
  - Re-assert en: period_start=1 with pwm high for 8 cycles from k=0.
- Assert rst asynchronously between edges at k=2 with duty 10:
  - pwm_signal, period_start and duty_active go to 0 immediately.
  - After release with en=1 and no load: period_start pulses and pwm_signal stays low (shadow=0).
